// File: rtl/p2s_pkg.sv
// Shared constants for the 4-lane parallel-to-serial sequencer: link bytes,
// FSM encoding and bit-period rate codes.
package p2s_pkg;

    localparam int          WIDTH      = 8;
    localparam logic [7:0]  SYNC_BYTE  = 8'hBC;
    localparam logic [7:0]  IDLE_BYTE  = 8'h7C;
    localparam int          SYNC_WORDS = 4;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] RATE_DIV1 = 2'd0;
    localparam logic [1:0] RATE_DIV2 = 2'd1;
    localparam logic [1:0] RATE_DIV4 = 2'd2;
    localparam logic [1:0] RATE_DIV8 = 2'd3;

    // Last prescaler count of a bit period, i.e. (1 << rate) - 1.
    function automatic logic [2:0] rate_last(input logic [1:0] rate);
        logic [2:0] last;
        case (rate)
            RATE_DIV1: last = 3'd0;
            RATE_DIV2: last = 3'd1;
            RATE_DIV4: last = 3'd3;
            default:   last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/p2s_tick_gen_cond.sv
// Bit-period prescaler. The rate is latched only on load cycles so a word is
// always serialised at a single rate.
module p2s_tick_gen_cond
    import p2s_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] IN_RATE,
    input  logic       load,
    output logic       tick
);

    logic [2:0] pcnt_q, pcnt_d;
    logic [1:0] lrate_q, lrate_d;

    assign tick = (pcnt_q == rate_last(lrate_q));

    always_comb begin
        pcnt_d  = tick ? 3'd0 : pcnt_q + 3'd1;
        lrate_d = load ? IN_RATE : lrate_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pcnt_q  <= 3'd0;
            lrate_q <= RATE_DIV1;
        end else begin
            pcnt_q  <= pcnt_d;
            lrate_q <= lrate_d;
        end
    end

endmodule

// File: rtl/p2s_ctrl_cond.sv
// Sequencer for the 4-lane parallel-to-serial datapath: sync preamble, word
// handshake, idle fill and MSB-first bit select.
module p2s_ctrl_cond
    import p2s_pkg::*;
#(
    parameter logic [7:0] P_SYNC_BYTE  = SYNC_BYTE,
    parameter logic [7:0] P_IDLE_BYTE  = IDLE_BYTE,
    parameter int         P_SYNC_WORDS = SYNC_WORDS
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [1:0]           IN_RATE_p2s,
    input  logic                 IN_VALID_p2s,
    input  logic [4*WIDTH-1:0]   IN_DATA_p2s,
    output logic                 OUT_READY_p2s,
    output logic                 OUT_ENB_p2s,
    output logic [WIDTH-1:0]     OUT_D3_p2s,
    output logic [WIDTH-1:0]     OUT_D2_p2s,
    output logic [WIDTH-1:0]     OUT_D1_p2s,
    output logic [WIDTH-1:0]     OUT_D0_p2s,
    output logic [2:0]           OUT_CTR_p2s,
    output logic                 OUT_LINK_UP_p2s
);

    localparam int SCNT_W = $clog2(P_SYNC_WORDS + 1);

    state_e              state_q, state_d;
    logic [2:0]          ctr_q, ctr_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                link_up_q, link_up_d;
    logic                tick, load;

    p2s_tick_gen_cond u_tick (
        .CLK     (CLK),
        .RESET   (RESET),
        .IN_RATE (IN_RATE_p2s),
        .load    (load),
        .tick    (tick)
    );

    // A load cycle is the tick that follows the LSB; reset state makes the
    // very first cycle one.
    assign load = tick && (ctr_q == 3'd0);

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        ctr_d   = ctr_q;
        if (load)
            ctr_d = 3'd7;
        else if (tick)
            ctr_d = ctr_q - 3'd1;
        if (load && state_q == ST_SYNC) begin
            scnt_d = scnt_q + SCNT_W'(1);
            if (scnt_q == SCNT_W'(P_SYNC_WORDS - 1))
                state_d = ST_RUN;
        end
        link_up_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_SYNC;
            ctr_q     <= 3'd0;
            scnt_q    <= '0;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            scnt_q    <= scnt_d;
            link_up_q <= link_up_d;
        end
    end

    always_comb begin
        OUT_D3_p2s = '0;
        OUT_D2_p2s = '0;
        OUT_D1_p2s = '0;
        OUT_D0_p2s = '0;
        if (load) begin
            if (state_q == ST_SYNC) begin
                OUT_D3_p2s = P_SYNC_BYTE;
                OUT_D2_p2s = P_SYNC_BYTE;
                OUT_D1_p2s = P_SYNC_BYTE;
                OUT_D0_p2s = P_SYNC_BYTE;
            end else if (IN_VALID_p2s) begin
                OUT_D3_p2s = IN_DATA_p2s[4*WIDTH-1:3*WIDTH];
                OUT_D2_p2s = IN_DATA_p2s[3*WIDTH-1:2*WIDTH];
                OUT_D1_p2s = IN_DATA_p2s[2*WIDTH-1:WIDTH];
                OUT_D0_p2s = IN_DATA_p2s[WIDTH-1:0];
            end else begin
                OUT_D3_p2s = P_IDLE_BYTE;
                OUT_D2_p2s = P_IDLE_BYTE;
                OUT_D1_p2s = P_IDLE_BYTE;
                OUT_D0_p2s = P_IDLE_BYTE;
            end
        end
    end

    assign OUT_ENB_p2s     = load;
    assign OUT_READY_p2s   = load && (state_q == ST_RUN);
    assign OUT_CTR_p2s     = ctr_q;
    assign OUT_LINK_UP_p2s = link_up_q;

endmodule

// File: tb/tb_p2s_ctrl_cond.sv
// Directed bench for the p2s sequencer: preamble, handshake pacing, rate
// change at word boundaries, mid-word reset and idle insertion.
module tb_p2s_ctrl_cond;

    logic        CLK;
    logic        RESET;
    logic [1:0]  IN_RATE_p2s;
    logic        IN_VALID_p2s;
    logic [31:0] IN_DATA_p2s;
    logic        OUT_READY_p2s;
    logic        OUT_ENB_p2s;
    logic [7:0]  OUT_D3_p2s, OUT_D2_p2s, OUT_D1_p2s, OUT_D0_p2s;
    logic [2:0]  OUT_CTR_p2s;
    logic        OUT_LINK_UP_p2s;

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;
    int          idx = 0;
    string       tname = "init";
    logic [31:0] words [16];

    p2s_ctrl_cond dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .IN_RATE_p2s     (IN_RATE_p2s),
        .IN_VALID_p2s    (IN_VALID_p2s),
        .IN_DATA_p2s     (IN_DATA_p2s),
        .OUT_READY_p2s   (OUT_READY_p2s),
        .OUT_ENB_p2s     (OUT_ENB_p2s),
        .OUT_D3_p2s      (OUT_D3_p2s),
        .OUT_D2_p2s      (OUT_D2_p2s),
        .OUT_D1_p2s      (OUT_D1_p2s),
        .OUT_D0_p2s      (OUT_D0_p2s),
        .OUT_CTR_p2s     (OUT_CTR_p2s),
        .OUT_LINK_UP_p2s (OUT_LINK_UP_p2s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s/%s: observed %h expected %h", tname, tag, obs, exp);
        end
    endtask

    // Walks ncyc cycles of a word schedule with period per, starting at
    // phase start. Expectations come from the phase; sync selects preamble.
    task automatic run_span(input int per, input int start, input int ncyc,
                            input bit tog, input bit sync);
        int          ph, hold;
        bit          ld, hs;
        logic [2:0]  cexp;
        logic [2:0]  ctr_exp;
        logic [31:0] dexp;
        hold = per / 8;
        for (int c = 0; c < ncyc; c++) begin
            ph = (start + c) % per;
            ld = (ph == 0);
            @(negedge CLK);
            if (!ld)
                dexp = 32'h0;
            else if (sync)
                dexp = 32'hBCBC_BCBC;
            else if (IN_VALID_p2s)
                dexp = words[idx];
            else
                dexp = 32'h7C7C_7C7C;
            cexp[2] = ld;
            cexp[1] = ld && !sync;
            cexp[0] = sync ? (c >= 25) : 1'b1;
            ctr_exp = ld ? 3'd0 : 3'(7 - (ph - 1) / hold);
            chk("enb_rdy_link", {29'd0, OUT_ENB_p2s, OUT_READY_p2s, OUT_LINK_UP_p2s}, {29'd0, cexp});
            chk("ctr", {29'd0, OUT_CTR_p2s}, {29'd0, ctr_exp});
            chk("lanes", {OUT_D3_p2s, OUT_D2_p2s, OUT_D1_p2s, OUT_D0_p2s}, dexp);
            hs = ld && !sync && IN_VALID_p2s;
            @(posedge CLK);
            #1;
            if (hs) idx++;
            if (ld && tog) IN_VALID_p2s = !IN_VALID_p2s;
            IN_DATA_p2s = words[idx];
        end
    endtask

    initial begin
        words[0] = 32'hA5C3_0F81;
        for (int i = 1; i < 16; i++)
            words[i] = 32'h1122_3344 * i ^ 32'h5A96_E13C;
        RESET        = 1'b1;
        IN_RATE_p2s  = 2'd0;
        IN_VALID_p2s = 1'b0;
        IN_DATA_p2s  = words[0];
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        tname = "preamble";
        run_span(8, 0, 32, 1'b0, 1'b1);
        tname = "first_idle";
        run_span(8, 0, 8, 1'b0, 1'b0);

        tname = "single_word";
        IN_VALID_p2s = 1'b1;
        run_span(8, 0, 1, 1'b0, 1'b0);
        chk("consumed", idx, 1);
        IN_VALID_p2s = 1'b0;
        run_span(8, 1, 7, 1'b0, 1'b0);

        tname = "stream_rate0";
        IN_VALID_p2s = 1'b1;
        run_span(8, 0, 32, 1'b0, 1'b0);
        chk("count_rate0", idx, 5);
        tname = "stream_rate3";
        IN_RATE_p2s = 2'd3;
        run_span(64, 0, 192, 1'b0, 1'b0);
        chk("count_rate3", idx, 8);

        tname = "rate_change";
        IN_RATE_p2s  = 2'd0;
        IN_VALID_p2s = 1'b0;
        run_span(8, 0, 4, 1'b0, 1'b0);
        IN_RATE_p2s = 2'd2;
        run_span(8, 4, 4, 1'b0, 1'b0);
        run_span(32, 0, 64, 1'b0, 1'b0);

        tname = "mid_reset";
        IN_RATE_p2s = 2'd0;
        run_span(8, 0, 5, 1'b0, 1'b0);
        RESET        = 1'b1;
        IN_VALID_p2s = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        run_span(8, 0, 32, 1'b0, 1'b1);
        chk("held_word", idx, 8);
        run_span(8, 0, 8, 1'b0, 1'b0);
        chk("post_reset_word", idx, 9);

        tname = "toggle_rate1";
        IN_RATE_p2s = 2'd1;
        run_span(16, 0, 64, 1'b1, 1'b0);
        chk("count_toggle", idx, 11);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
